uart_tx_queue: RTL and testbench

Byte queue and launch controller between on-chip byte producers and the `uart` transmitter. Producers push bytes at any rate up to one per clock. The block buffers them in a FIFO and issues one-cycle `transmit` pulses to the UART only when the transmitter is idle. It replaces the direct `received -> transmit` echo path, so bursts are no longer lost while `is_transmitting` is high.

---
 rtl/uart_tx_queue_pkg.sv | 11 +
 rtl/uart_tx_queue_byte_fifo.sv | 58 +++++
 rtl/uart_tx_queue.sv | 84 ++++++++
 tb/tb_uart_tx_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// uart_tx_queue_pkg: launch FSM encoding and default sizing shared by the TX and RX queues.
package uart_tx_queue_pkg;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_e;
    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_START_TIMEOUT = 4;
endpackage

// File: rtl/uart_tx_queue_byte_fifo.sv
// byte_fifo: circular byte buffer with wrapping pointers, separate occupancy count
// and a one-cycle pulse for each push dropped while full.
module byte_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d, push_ok, pop_ok;

    // Acceptance looks only at the start-of-cycle count, so a same-cycle pop never rescues a push.
    always_comb begin
        push_ok    = push && (count_q != (AW+1)'(DEPTH));
        pop_ok     = pop && (count_q != '0);
        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(pop_ok);
        count_d    = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        overflow_d = push && !push_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = count_q == (AW+1)'(DEPTH);
    assign empty    = count_q == '0;
    assign overflow = overflow_q;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers producer bytes and launches them into the UART one at a time,
// reissuing a launch the UART failed to acknowledge.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          retry,
    input  logic          tx_busy,
    output logic          transmit,
    output logic [7:0]    tx_byte
);
    localparam int TW = $clog2(START_TIMEOUT);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    tx_byte_q, tx_byte_d, head;
    logic          transmit_q, transmit_d, retry_q, retry_d, pop, timeout;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // Timer holds cycles already spent in WAIT_START; this cycle would be the last one allowed.
    assign timeout = (state_q == WAIT_START) && !tx_busy && (timer_q == TW'(START_TIMEOUT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            tx_byte_q  <= 8'h00;
            transmit_q <= 1'b0;
            retry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
            retry_q    <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       state_d = (!empty && !tx_busy) ? LAUNCH : IDLE;
            LAUNCH:     state_d = WAIT_START;
            WAIT_START: state_d = tx_busy ? WAIT_DONE : (timeout ? LAUNCH : WAIT_START);
            WAIT_DONE:  state_d = tx_busy ? WAIT_DONE : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        pop        = (state_q == IDLE) && !empty && !tx_busy;
        tx_byte_d  = pop ? head : tx_byte_q;
        transmit_d = state_d == LAUNCH;
        retry_d    = timeout;
        timer_d    = (state_q == LAUNCH) ? '0 : (state_q == WAIT_START) ? timer_q + TW'(1) : timer_q;
    end

    assign transmit = transmit_q;
    assign retry    = retry_q;
    assign tx_byte  = tx_byte_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed scenarios plus random traffic against a queue-level
// reference model and a behavioural UART that can drop launches.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int START_TIMEOUT = 4;

    logic                     clk = 1'b0;
    logic                     rst_n, wr_en, tx_busy;
    logic [7:0]               wr_data, tx_byte;
    logic                     full, empty, overflow, retry, transmit;
    logic [$clog2(DEPTH):0]   count;

    int vectors = 0, miscompares = 0;
    logic [7:0] mq [$];
    logic [7:0] last_byte = 8'h00;
    int  m_cnt = 0, since = 1000, uart_cnt = 0, ignore_n = 0, lo = 1, hi = 1;
    int  retries = 0, launches = 0, ovf_seen = 0, full_seen = 0;
    bit  acc_prev = 0, ovf_prev = 0, tx_prev = 0, busy_seen = 0, force_busy = 0;

    uart_tx_queue #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .retry    (retry),
        .tx_busy  (tx_busy),
        .transmit (transmit),
        .tx_byte  (tx_byte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1ns after an edge: check this cycle's outputs, update the UART model, drive the next inputs.
    task automatic cycle(input bit we, input logic [7:0] d);
        bit fresh;
        logic [7:0] exp;
        since++;
        if (since >= 2 && since <= START_TIMEOUT && tx_busy) busy_seen = 1;
        chk("retry", retry, since == START_TIMEOUT && !busy_seen);
        chk("no_back_to_back", transmit && tx_prev, 0);
        if (retry) retries++;
        fresh = transmit && !retry;
        if (fresh) begin
            launches++;
            chk("launch_when_idle", tx_busy, 0);
            chk("launch_nonempty", m_cnt > 0, 1);
            exp = (mq.size() > 0) ? mq.pop_front() : 8'h00;
            chk("tx_byte", tx_byte, exp);
            last_byte = exp;
        end else if (transmit) begin
            chk("retry_byte", tx_byte, last_byte);
        end
        if (transmit) begin
            since = 0;
            busy_seen = 0;
        end
        m_cnt = m_cnt + int'(acc_prev) - int'(fresh);
        chk("count", count, m_cnt);
        chk("empty", empty, m_cnt == 0);
        chk("full", full, m_cnt == DEPTH);
        chk("overflow", overflow, ovf_prev);
        if (overflow) ovf_seen++;
        if (full) full_seen++;
        if (uart_cnt > 0) uart_cnt--;
        if (tx_prev) begin
            if (ignore_n > 0) ignore_n--;
            else uart_cnt = $urandom_range(hi, lo);
        end
        tx_busy = force_busy || uart_cnt > 0;
        tx_prev = transmit;
        wr_en = we;
        wr_data = d;
        acc_prev = we && m_cnt < DEPTH;
        ovf_prev = we && m_cnt == DEPTH;
        if (acc_prev) mq.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (!(mq.size() == 0 && uart_cnt == 0 && !force_busy && since > START_TIMEOUT + 2) && n < 3000) begin
            cycle(0, 8'h00);
            n++;
        end
        repeat (3) cycle(0, 8'h00);
        chk("drain_timeout", n < 3000, 1);
    endtask

    initial begin
        int r0, l0, o0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        tx_busy = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_transmit", transmit, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_retry", retry, 0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle(0, 8'h00);

        // single byte: push at N, count 1 at N+1, transmit at N+2 with count back to 0
        lo = 4; hi = 4;
        cycle(1, 8'hA5);
        chk("single_n1_transmit", transmit, 0);
        chk("single_n1_count", count, 1);
        cycle(0, 8'h00);
        chk("single_n2_transmit", transmit, 1);
        chk("single_n2_byte", tx_byte, 8'hA5);
        chk("single_n2_count", count, 0);
        drain();

        // burst of 16 consecutive pushes
        lo = 3; hi = 12;
        o0 = ovf_seen;
        l0 = launches;
        for (int i = 0; i < 16; i++) cycle(1, 8'h30 + 8'(i));
        drain();
        chk("burst_no_overflow", ovf_seen - o0, 0);
        chk("burst_launches", launches - l0, 16);

        // overflow with the UART held busy
        force_busy = 1;
        o0 = ovf_seen;
        for (int i = 0; i < 18; i++) cycle(1, 8'h80 + 8'(i));
        cycle(0, 8'h00);
        chk("ovf_full", full, 1);
        chk("ovf_count", count, DEPTH);
        chk("ovf_pulses", ovf_seen - o0, 2);
        force_busy = 0;
        drain();

        // retry: the UART drops the first launch
        lo = 5; hi = 5;
        ignore_n = 1;
        r0 = retries;
        cycle(1, 8'h5C);
        repeat (14) cycle(0, 8'h00);
        chk("retry_pulses", retries - r0, 1);
        drain();

        // reset during WAIT_DONE with five bytes queued
        lo = 60; hi = 60;
        for (int i = 0; i < 6; i++) cycle(1, 8'($urandom));
        repeat (2) cycle(0, 8'h00);
        chk("pre_reset_count", count, 5);
        chk("pre_reset_busy", tx_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_transmit", transmit, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_tx_byte", tx_byte, 8'h00);
        mq.delete();
        m_cnt = 0;
        acc_prev = 0;
        ovf_prev = 0;
        tx_prev = 0;
        since = 1000;
        #2 rst_n = 1'b1;
        l0 = launches;
        lo = 2; hi = 6;
        cycle(1, 8'h77);
        repeat (90) cycle(0, 8'h00);
        chk("post_reset_launch", launches - l0, 1);
        drain();

        // wrap-around: one push per launch period for 3*DEPTH bytes
        lo = 1; hi = 1;
        full_seen = 0;
        l0 = launches;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1, 8'($urandom));
            repeat (3) cycle(0, 8'h00);
        end
        drain();
        chk("wrap_never_full", full_seen, 0);
        chk("wrap_launches", launches - l0, 3 * DEPTH);

        // random traffic with occasional dropped launches
        lo = 1; hi = 20;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(49, 0) == 0) ignore_n = 1;
            cycle($urandom_range(1, 0) == 1, 8'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
